addsub_arbiter: RTL and testbench

- Shares one combinational 4-bit add/subtract unit between two requesters (e.g. switch-input path and a sequencer path).
- Arbitrates between the requesters and drives the unit's a/b/sub inputs from registers.
- Captures sum/carry, derives signed overflow, and returns a tagged response under valid/ready handshake for the 7-segment display stage.

---
 rtl/addsub_arbiter.sv | 178 +++++++++++++++++
 tb/tb_addsub_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one external combinational W-bit add/subtract unit between two
// requesters. A granted operation is latched into the au_* registers, the unit's result is
// captured one cycle later together with a derived signed-overflow flag, and a tagged
// response is held under a valid/ready handshake.
// Optional statistics (grant and overflow counters): define ADDSUB_ARB_STATS_EN.
module addsub_arbiter #(
    parameter int unsigned W          = 4,
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic         clk,
    input  logic         rst,
    // requester 0
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    output logic         req0_ready,
    // requester 1
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic         req1_ready,
    // shared add/sub unit
    output logic [W-1:0] au_a,
    output logic [W-1:0] au_b,
    output logic         au_sub,
    input  logic [W-1:0] au_sum,
    input  logic         au_cout,
    // response
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf,
    output logic         busy
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [7:0]   stat_grant0,
    output logic [7:0]   stat_grant1,
    output logic [7:0]   stat_ovf
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant0, grant1;
    logic   id_q;
    logic   last_q;
    logic   [W-1:0] b_eff;
    logic   ovf_calc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration and next-state; grants are combinational so ready pulses in the accept cycle.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Requester 0 wins when alone, under fixed priority, or when 1 went last.
                if (req0_valid && (!req1_valid || (PRIO_FIXED != 0) || last_q)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state_q != StIdle);

    // Signed overflow: operands of equal sign whose result flips sign. The unit inverts b for sub.
    always_comb begin
        b_eff    = au_b ^ {W{au_sub}};
        ovf_calc = (au_a[W-1] == b_eff[W-1]) && (au_sum[W-1] != au_a[W-1]);
    end

    // Operand registers feeding the unit; they keep the last operation until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            au_a   <= '0;
            au_b   <= '0;
            au_sub <= 1'b0;
            id_q   <= 1'b0;
        end else if (grant0) begin
            au_a   <= req0_a;
            au_b   <= req0_b;
            au_sub <= req0_sub;
            id_q   <= 1'b0;
        end else if (grant1) begin
            au_a   <= req1_a;
            au_b   <= req1_b;
            au_sub <= req1_sub;
            id_q   <= 1'b1;
        end
    end

    // Response capture in EXEC and handshake completion in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_sum   <= au_sum;
            rsp_cout  <= au_cout;
            rsp_ovf   <= ovf_calc;
        end else if ((state_q == StResp) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer: records who was served; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (state_q == StExec) begin
            last_q <= id_q;
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    // Saturating grant and overflow counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0 <= 8'd0;
            stat_grant1 <= 8'd0;
            stat_ovf    <= 8'd0;
        end else begin
            if (grant0 && (stat_grant0 != 8'hFF)) begin
                stat_grant0 <= stat_grant0 + 8'd1;
            end
            if (grant1 && (stat_grant1 != 8'hFF)) begin
                stat_grant1 <= stat_grant1 + 8'd1;
            end
            if ((state_q == StExec) && ovf_calc && (stat_ovf != 8'hFF)) begin
                stat_ovf <= stat_ovf + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: a round-robin instance and a fixed-priority instance share
// stimulus; each has its own behavioural add/sub unit. Expected results come from signed and
// unsigned integer arithmetic and a simple arbitration model.
module tb_addsub_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_sub, req1_valid, req1_sub;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_ready;

    // round-robin instance
    logic       req0_ready, req1_ready;
    logic [3:0] au_a, au_b, au_sum, rsp_sum;
    logic       au_sub, au_cout, rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
    // fixed-priority instance
    logic       f_req0_ready, f_req1_ready;
    logic [3:0] f_au_a, f_au_b, f_au_sum, f_rsp_sum;
    logic       f_au_sub, f_au_cout, f_rsp_valid, f_rsp_id, f_rsp_cout, f_rsp_ovf, f_busy;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] stat_grant0, stat_grant1, stat_ovf;
    logic [7:0] f_stat_grant0, f_stat_grant1, f_stat_ovf;
`endif

    int n_tests;
    int n_fail;
    int model_last;

    // Behavioural add/sub units: sum = a + (b ^ {sub}) + sub.
    assign {au_cout, au_sum} = {1'b0, au_a} + {1'b0, au_b ^ {4{au_sub}}} + {4'd0, au_sub};
    assign {f_au_cout, f_au_sum} =
        {1'b0, f_au_a} + {1'b0, f_au_b ^ {4{f_au_sub}}} + {4'd0, f_au_sub};

    addsub_arbiter #(.W(4), .PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .req1_ready(req1_ready),
        .au_a(au_a), .au_b(au_b), .au_sub(au_sub), .au_sum(au_sum), .au_cout(au_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
`ifdef ADDSUB_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_ovf(stat_ovf)
`endif
    );

    addsub_arbiter #(.W(4), .PRIO_FIXED(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req0_ready(f_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .req1_ready(f_req1_ready),
        .au_a(f_au_a), .au_b(f_au_b), .au_sub(f_au_sub), .au_sum(f_au_sum),
        .au_cout(f_au_cout),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_sum(f_rsp_sum), .rsp_cout(f_rsp_cout), .rsp_ovf(f_rsp_ovf), .busy(f_busy)
`ifdef ADDSUB_ARB_STATS_EN
        , .stat_grant0(f_stat_grant0), .stat_grant1(f_stat_grant1), .stat_ovf(f_stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic void ref_addsub(input int a, input int b, input bit sub,
                                       output logic [3:0] sum, output bit cout,
                                       output bit ovf);
        int r, sa, sb, sr;
        if (sub) begin
            r    = a - b;
            cout = (a >= b);
        end else begin
            r    = a + b;
            cout = (r > 15);
        end
        sum = 4'(r & 15);
        sa  = (a > 7) ? a - 16 : a;
        sb  = (b > 7) ? b - 16 : b;
        sr  = sub ? sa - sb : sa + sb;
        ovf = (sr > 7) || (sr < -8);
    endfunction

    // One full transaction; starts and ends just after a rising edge with both DUTs idle.
    task automatic run_op(input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                          input bit s0, input bit v1, input logic [3:0] a1,
                          input logic [3:0] b1, input bit s1, input int hold, input bit keep);
        int         id, fid;
        logic [3:0] ea, eb, fa, fb, esum, fsum;
        bit         es, fs, ecout, eovf, fcout, fovf;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready  = 1'b0;
        id  = (v0 && (!v1 || model_last == 1)) ? 0 : 1;
        fid = v0 ? 0 : 1;
        ea = (id == 0) ? a0 : a1;  eb = (id == 0) ? b0 : b1;  es = (id == 0) ? s0 : s1;
        fa = (fid == 0) ? a0 : a1; fb = (fid == 0) ? b0 : b1; fs = (fid == 0) ? s0 : s1;
        ref_addsub(int'(ea), int'(eb), es, esum, ecout, eovf);
        ref_addsub(int'(fa), int'(fb), fs, fsum, fcout, fovf);
        // accept cycle
        @(negedge clk);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("grant_ready0", 8'(req0_ready), 8'(id == 0));
        chk("grant_ready1", 8'(req1_ready), 8'(id == 1));
        chk("fixed_ready0", 8'(f_req0_ready), 8'(fid == 0));
        chk("fixed_ready1", 8'(f_req1_ready), 8'(fid == 1));
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        // execute cycle
        @(negedge clk);
        chk("exec_busy", 8'(busy), 8'd1);
        chk("exec_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("exec_ready", 8'({req0_ready, req1_ready, f_req0_ready, f_req1_ready}), 8'd0);
        @(posedge clk); #1;
        // response cycles: hold stalls, then one accepting cycle
        for (int k = 0; k <= hold; k++) begin
            rsp_ready = (k == hold);
            @(negedge clk);
            chk("rsp_valid", 8'(rsp_valid), 8'd1);
            chk("rsp_id", 8'(rsp_id), 8'(id));
            chk("rsp_sum", 8'(rsp_sum), 8'(esum));
            chk("rsp_cout", 8'(rsp_cout), 8'(ecout));
            chk("rsp_ovf", 8'(rsp_ovf), 8'(eovf));
            chk("rsp_au_ops", {au_sub, au_b[2:0], au_a}, {es, eb[2:0], ea});
            chk("rsp_busy", 8'(busy), 8'd1);
            chk("rsp_ready_low", 8'({req0_ready, req1_ready, f_req0_ready, f_req1_ready}), 8'd0);
            chk("fixed_rsp_id", 8'(f_rsp_id), 8'(fid));
            chk("fixed_rsp", {f_rsp_valid, f_rsp_ovf, f_rsp_cout, 1'b0, f_rsp_sum},
                {1'b1, fovf, fcout, 1'b0, fsum});
            @(posedge clk); #1;
        end
        rsp_ready  = 1'b0;
        model_last = id;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        model_last = 1;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_sub = 1'b0;
        rsp_ready  = 1'b0;
        rst        = 1'b1;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_au", {au_sub, au_b[2:0], au_a}, 8'd0);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum}, 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_ready", 8'({req0_ready, req1_ready}), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single-requester directed operations
        run_op(1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 0, 1'b0);
        run_op(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 4'd2, 1'b1, 0, 1'b0);
        run_op(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd7, 1'b1, 0, 1'b0);

        // both requesters continuously valid: round-robin alternates, fixed always picks 0
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 4'd9, 4'd3, 1'b1, 0, 1'b1);
        end

        // consumer stalls for 5 cycles
        run_op(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 5, 1'b0);

        // reset during EXEC discards the operation and restores the pointer
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd1; req0_sub = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rstx_ready0", 8'(req0_ready), 8'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        chk("rstx_exec_busy", 8'(busy), 8'd1);
        @(posedge clk); #1;
        rst        = 1'b0;
        model_last = 1;
        @(negedge clk);
        chk("rstx_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rstx_busy", 8'({busy, f_busy}), 8'd0);
        chk("rstx_au_a", 8'(au_a), 8'd0);
        @(posedge clk); #1;
        run_op(1'b1, 4'd8, 4'd8, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 0, 1'b0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            run_op(sel[0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), sel[1], 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef ADDSUB_ARB_STATS_EN
        // saturating statistics
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        model_last = 1;
        chk("stat_clear", stat_grant0 | stat_grant1 | stat_ovf, 8'd0);
        for (int i = 0; i < 300; i++) begin
            run_op(1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 0, 1'b0);
        end
        chk("stat_grant0", stat_grant0, 8'd255);
        chk("stat_ovf", stat_ovf, 8'd255);
        chk("stat_grant1", stat_grant1, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
